// File: rtl/writeback_queue_pkg.sv
// Shared definitions for the register-file write-back queue.
//   REGISTER_NUMBER_LOG : register index width (32 registers)
//   DATA_WIDTH          : result width
//   wb_entry_t          : one queued result, {index, value}
package writeback_queue_pkg;
  localparam int REGISTER_NUMBER_LOG = 5;
  localparam int DATA_WIDTH          = 32;

  typedef struct packed {
    logic [REGISTER_NUMBER_LOG-1:0] index;
    logic [DATA_WIDTH-1:0]          value;
  } wb_entry_t;
endpackage

// File: rtl/writeback_fifo.sv
// In-order storage for pending write-back results.
//   clk, rst_n          : clock, async active-low reset (drops all entries)
//   push_a / entry_a    : first (older) push of the cycle
//   push_b / entry_b    : second (younger) push of the cycle
//   pop                 : retire the head entry (caller guarantees non-empty)
//   count, full         : occupancy and full flag
//   head                : oldest entry
//   ordered/ordered_vld : entries re-ordered oldest-first, with occupancy mask,
//                         for the forwarding search
module writeback_fifo
  import writeback_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_a,
  input  wb_entry_t               entry_a,
  input  logic                    push_b,
  input  wb_entry_t               entry_b,
  input  logic                    pop,
  output logic [CW-1:0]           count,
  output logic                    full,
  output wb_entry_t               head,
  output wb_entry_t [DEPTH-1:0]   ordered,
  output logic      [DEPTH-1:0]   ordered_vld
);
  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] wr_nxt;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_nxt   = wr_ptr_q + CW'(1);
    if (push_a && push_b) begin
      mem_d[wr_ptr_q[AW-1:0]] = entry_a;
      mem_d[wr_nxt[AW-1:0]]   = entry_b;
      wr_ptr_d                = wr_ptr_q + CW'(2);
    end else if (push_a) begin
      mem_d[wr_ptr_q[AW-1:0]] = entry_a;
      wr_ptr_d                = wr_nxt;
    end else if (push_b) begin
      mem_d[wr_ptr_q[AW-1:0]] = entry_b;
      wr_ptr_d                = wr_nxt;
    end
    if (pop) rd_ptr_d = rd_ptr_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head  = ordered[0];

  for (genvar k = 0; k < DEPTH; k++) begin : g_ord
    assign ordered[k]     = mem_q[rd_ptr_q[AW-1:0] + AW'(k)];
    assign ordered_vld[k] = CW'(k) < count;
  end
endmodule

// File: rtl/writeback_queue.sv
// Register-file write-back queue: accepts results from the memory and ALU
// stages, retires one per cycle onto the single RF write port, and forwards
// pending values to the two decode read indices.
//   clk, reset                      : clock, async active-low reset
//   memValid/memReady/memIndex/memValue : memory-stage result handshake
//   aluValid/aluReady/aluIndex/aluValue : ALU-stage result handshake
//   writeIndex/writeValue           : RF write port (0/0 when idle)
//   readIndexA/B                    : decode read indices
//   forwardHitA/B, forwardValueA/B  : newest pending match (0 on miss)
//   pendingCount                    : occupied entries
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           memValid,
  output logic                           memReady,
  input  logic [REGISTER_NUMBER_LOG-1:0] memIndex,
  input  logic [DATA_WIDTH-1:0]          memValue,
  input  logic                           aluValid,
  output logic                           aluReady,
  input  logic [REGISTER_NUMBER_LOG-1:0] aluIndex,
  input  logic [DATA_WIDTH-1:0]          aluValue,
  output logic [REGISTER_NUMBER_LOG-1:0] writeIndex,
  output logic [DATA_WIDTH-1:0]          writeValue,
  input  logic [REGISTER_NUMBER_LOG-1:0] readIndexA,
  input  logic [REGISTER_NUMBER_LOG-1:0] readIndexB,
  output logic                           forwardHitA,
  output logic                           forwardHitB,
  output logic [DATA_WIDTH-1:0]          forwardValueA,
  output logic [DATA_WIDTH-1:0]          forwardValueB,
  output logic [CW-1:0]                  pendingCount
);
  logic [CW-1:0]         count;
  logic                  full;
  logic                  push_a, push_b, pop;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] ordered;
  logic      [DEPTH-1:0] ordered_vld;

  // Readiness uses the current occupancy only; the same-cycle pop earns no
  // credit. Memory claims a lone free slot, ALU needs two or an idle memory.
  assign memReady = !full;
  assign aluReady = (count <= CW'(DEPTH - 2)) || (!full && !memValid);

  // Index-0 results complete the handshake but are discarded.
  assign push_a = memValid && memReady && (memIndex != '0);
  assign push_b = aluValid && aluReady && (aluIndex != '0);
  assign pop    = count != '0;

  writeback_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_a      (push_a),
    .entry_a     ('{index: memIndex, value: memValue}),
    .push_b      (push_b),
    .entry_b     ('{index: aluIndex, value: aluValue}),
    .pop         (pop),
    .count       (count),
    .full        (full),
    .head        (head),
    .ordered     (ordered),
    .ordered_vld (ordered_vld)
  );

  assign pendingCount = count;
  assign writeIndex   = pop ? head.index : '0;
  assign writeValue   = pop ? head.value : '0;

  // Forwarding: scan oldest to newest so the youngest match overwrites.
  logic [1:0][REGISTER_NUMBER_LOG-1:0] rd_idx;
  logic [1:0]                          fwd_hit;
  logic [1:0][DATA_WIDTH-1:0]          fwd_val;

  assign rd_idx = {readIndexB, readIndexA};

  for (genvar p = 0; p < 2; p++) begin : g_fwd
    logic                  hit;
    logic [DATA_WIDTH-1:0] val;
    always_comb begin
      hit = 1'b0;
      val = '0;
      for (int k = 0; k < DEPTH; k++) begin
        if (ordered_vld[k] && (rd_idx[p] != '0) && (ordered[k].index == rd_idx[p])) begin
          hit = 1'b1;
          val = ordered[k].value;
        end
      end
    end
    assign fwd_hit[p] = hit;
    assign fwd_val[p] = val;
  end

  assign forwardHitA   = fwd_hit[0];
  assign forwardHitB   = fwd_hit[1];
  assign forwardValueA = fwd_val[0];
  assign forwardValueB = fwd_val[1];
endmodule
